vospi_packet_sequencer: RTL
===========================

// Module: vospi_packet_sequencer
// PURPOSE
//  Sequences the raw VoSPI byte stream from the SPI receiver into pixel_collector: parses each
//  164-byte packet (2B ID, 2B CRC, 160B payload), drops discard packets and strips headers.
//  Forwards only in-order payload bytes and tracks line/frame position.
//  Sits between spi byte receiver and pixel_collector; flags loss of sync to the upstream controller.
// PARAMETERS
//  width_p          80    pixels per line (one packet = one line)
//  lines_p          60    lines (packets) per frame
//  pixel_bytes_p    2     bytes per pixel; payload bytes = width_p*pixel_bytes_p (160)
//  timeout_cycles_p 1024  idle cycles mid-packet before abort
// PORTS
//  clk_i         in   1   clock
//  reset_i       in   1   asynchronous active-high reset
//  data_i        in   8   SPI byte
//  valid_i       in   1   data_i strobe, one cycle per byte, no backpressure
//  coll_data_o   out  8   payload byte to pixel_collector.data_i
//  coll_valid_o  out  1   payload strobe to pixel_collector.valid_i
//  line_o        out  $clog2(lines_p)  packet number of the payload being forwarded
//  frame_start_o out  1   pulse with first payload byte of line 0
//  frame_done_o  out  1   pulse with last payload byte of line lines_p-1
//  sync_err_o    out  1   pulse on out-of-order packet, timeout or (opt) CRC error
//  discard_o     out  1   pulse at ID_LO of a discard packet
// BEHAVIOUR
//  - Reset (async): all outputs 0, state ID_HI, byte_cnt 0, expected_line 0, idle_cnt 0.
//  - FSM, one transition per accepted byte: ID_HI -> ID_LO -> CRC_HI -> CRC_LO -> PAYLOAD (160 B) -> ID_HI.
//    PAYLOAD has sub-mode fwd/drop latched at ID_LO.
//  - Discard: ID_HI[3:0]==4'hF. discard_o pulses, payload dropped, expected_line unchanged.
//  - Packet number = {ID_HI[3:0],ID_LO} (12 b). Evaluated at the ID_LO byte:
//    * num==0: accept, line_o<=0, expected<=1.
//      sync_err_o pulses if expected!=0 (restart mid-frame).
//    * num==expected && num<lines_p: accept, expected<=num+1.
//    * otherwise: sync_err_o pulses, payload dropped, expected<=0 (hunt for line 0).
//  - Accepted payload: coll_data_o/coll_valid_o are registered copies of data_i/valid_i.
//    Latency exactly 1 cycle; headers never forwarded.
//  - frame_start_o coincides with coll_valid_o of byte 0 of line 0.
//    frame_done_o coincides with byte 159 of line lines_p-1, which also sets expected<=0.
//  - Timeout: idle_cnt clears on valid_i and increments otherwise (saturating).
//    On reaching timeout_cycles_p with byte_cnt!=0: FSM->ID_HI, byte_cnt<=0, expected<=0,
//    one sync_err_o pulse. Idle in ID_HI never times out.
//  - Pulse outputs are single-cycle; coincident error sources produce one pulse.
//  - Reset mid-packet: immediate return to reset state; the partial pixel in pixel_collector
//    is that block's concern.
// CONFIGURATION
//  VOSPI_CRC_CHECK_EN defined:
//   - CRC-16-CCITT (poly 0x1021, init 0x0000, MSB first) over all 164 bytes,
//     with ID[15:12] and both CRC bytes taken as 0.
//   - Compared with the received CRC after the last payload byte.
//   - On mismatch: sync_err_o pulses one cycle after byte 163, expected<=0, and frame_done_o
//     is suppressed. Bytes already forwarded are not recalled.
//   - Discard packets are not checked.
//  VOSPI_CRC_CHECK_EN undefined: CRC bytes are ignored; no CRC logic is instantiated.
// STRUCTURE
//  vospi_pkg: state enum (ID_HI, ID_LO, CRC_HI, CRC_LO, PAYLOAD), VOSPI_HDR_BYTES=4,
//   VOSPI_DISCARD_NIBBLE=4'hF, CRC poly constant.
//  Sub-module vospi_crc16 (byte-wide serial CRC, clear/enable/data), instantiated only under
//   VOSPI_CRC_CHECK_EN.
// TESTING
//  1. Frame of 60 packets, IDs 0..59, ramp payload -> 9600 coll_valid_o pulses equal to payload,
//     one frame_start_o, one frame_done_o.
//  2. ID 0x0F00 packet between lines 5 and 6 -> discard_o pulse, no coll_valid_o for 160 bytes,
//     line 6 still accepted.
//  3. Lines 0..9 then ID 10 skipped (ID 11 sent) -> sync_err_o at ID_LO, line 11 dropped,
//     next ID 0 restarts frame_start_o.
//  4. Stop valid_i for 1024 cycles at payload byte 50 -> sync_err_o once, next byte parsed as ID_HI.
//  5. Assert reset_i mid-payload -> all outputs 0 asynchronously, next packet ID 0 accepted normally.
//  6. (VOSPI_CRC_CHECK_EN) corrupt one payload byte of line 59 -> sync_err_o one cycle after
//     last byte, no frame_done_o; correct CRC -> no error.

Source files
------------

// File: rtl/vospi_pkg.sv
// vospi_pkg: shared types and constants for the VoSPI packet sequencer.
package vospi_pkg;

  typedef enum logic [2:0] {
    ID_HI   = 3'd0,
    ID_LO   = 3'd1,
    CRC_HI  = 3'd2,
    CRC_LO  = 3'd3,
    PAYLOAD = 3'd4
  } vospi_state_t;

  localparam int          VOSPI_HDR_BYTES      = 4;
  localparam logic [3:0]  VOSPI_DISCARD_NIBBLE = 4'hF;
  localparam logic [15:0] VOSPI_CRC_POLY       = 16'h1021;

  // One byte of CRC-16-CCITT, MSB first.
  function automatic logic [15:0] vospi_crc16_byte(input logic [15:0] crc,
                                                   input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ VOSPI_CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/vospi_packet_sequencer_crc16.sv
// vospi_crc16: byte-serial CRC-16-CCITT accumulator. crc_o is the CRC
// including the byte currently presented on data_i, so the final value is
// available combinationally while the last byte is being accepted.
module vospi_crc16
  import vospi_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] r_crc;
  logic [15:0] w_base;

  // Restart from the zero seed when clear_i marks the first byte of a packet.
  always_comb begin
    w_base = clear_i ? 16'h0000 : r_crc;
    crc_o  = vospi_crc16_byte(w_base, data_i);
  end

  // Accumulate on every accepted byte.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_crc <= 16'h0000;
    else if (en_i) r_crc <= crc_o;
  end

endmodule

// File: rtl/vospi_packet_sequencer.sv
// vospi_packet_sequencer: parses 164-byte VoSPI packets from the SPI byte
// receiver, drops discard/out-of-order packets, strips headers and forwards
// in-order payload bytes to pixel_collector with one cycle of latency.
// Optional CRC verification is built when VOSPI_CRC_CHECK_EN is defined.
module vospi_packet_sequencer
  import vospi_pkg::*;
#(
  parameter int width_p          = 80,
  parameter int lines_p          = 60,
  parameter int pixel_bytes_p    = 2,
  parameter int timeout_cycles_p = 1024
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [7:0]                 data_i,
  input  logic                       valid_i,
  output logic [7:0]                 coll_data_o,
  output logic                       coll_valid_o,
  output logic [$clog2(lines_p)-1:0] line_o,
  output logic                       frame_start_o,
  output logic                       frame_done_o,
  output logic                       sync_err_o,
  output logic                       discard_o
);

  localparam int          PAYLOAD_BYTES = width_p * pixel_bytes_p;
  localparam int          LINE_W        = $clog2(lines_p);
  localparam int          IDLE_W        = $clog2(timeout_cycles_p + 1);
  localparam logic [7:0]  HDR_CNT       = 8'(VOSPI_HDR_BYTES);
  localparam logic [7:0]  LAST_BYTE     = 8'(VOSPI_HDR_BYTES + PAYLOAD_BYTES - 1);
  localparam logic [11:0] LINES_NUM     = 12'(lines_p);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(lines_p - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(timeout_cycles_p);
  localparam logic [IDLE_W-1:0] IDLE_TRIP = IDLE_W'(timeout_cycles_p - 1);

  vospi_state_t      r_state, w_state_nx;
  logic [7:0]        r_byte_cnt, w_byte_cnt_nx;
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_nx;
  logic [11:0]       r_expected, w_expected_nx;
  logic [3:0]        r_id_nib, w_id_nib_nx;
  logic              r_fwd, w_fwd_nx;
  logic [LINE_W-1:0] r_line, w_line_nx;
  logic [7:0]        r_coll_data, w_coll_data_nx;
  logic              r_coll_valid, w_coll_valid_nx;
  logic              r_frame_start, w_frame_start_nx;
  logic              r_frame_done, w_frame_done_nx;
  logic              r_sync_err, w_sync_err_nx;
  logic              r_discard, w_discard_nx;
  logic [11:0]       w_num;
  logic              w_crc_ok;

`ifdef VOSPI_CRC_CHECK_EN
  logic [15:0] r_crc_rx;
  logic [15:0] w_crc_calc;
  logic [7:0]  w_crc_byte;

  // The CRC covers the packet with ID[15:12] and both CRC bytes forced to zero.
  always_comb begin
    w_crc_byte = data_i;
    case (r_state)
      ID_HI:          w_crc_byte = {4'h0, data_i[3:0]};
      CRC_HI, CRC_LO: w_crc_byte = 8'h00;
      default:        w_crc_byte = data_i;
    endcase
  end

  vospi_crc16 u_crc16 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (r_state == ID_HI),
    .en_i    (valid_i),
    .data_i  (w_crc_byte),
    .crc_o   (w_crc_calc)
  );

  // Capture the transmitted CRC for comparison at the last payload byte.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_crc_rx <= 16'h0000;
    else if (valid_i && r_state == CRC_HI) r_crc_rx[15:8] <= data_i;
    else if (valid_i && r_state == CRC_LO) r_crc_rx[7:0]  <= data_i;
  end

  assign w_crc_ok = (w_crc_calc == r_crc_rx);
`else
  assign w_crc_ok = 1'b1;
`endif

  assign w_num = {r_id_nib, data_i};

  // Next-state and output decode: one transition per accepted byte, plus the idle timeout.
  always_comb begin
    w_state_nx       = r_state;
    w_byte_cnt_nx    = r_byte_cnt;
    w_expected_nx    = r_expected;
    w_id_nib_nx      = r_id_nib;
    w_fwd_nx         = r_fwd;
    w_line_nx        = r_line;
    w_coll_data_nx   = r_coll_data;
    w_coll_valid_nx  = 1'b0;
    w_frame_start_nx = 1'b0;
    w_frame_done_nx  = 1'b0;
    w_sync_err_nx    = 1'b0;
    w_discard_nx     = 1'b0;
    w_idle_cnt_nx    = valid_i ? '0 :
                       (r_idle_cnt == IDLE_MAX) ? r_idle_cnt : r_idle_cnt + 1'b1;

    if (valid_i) begin
      w_byte_cnt_nx = r_byte_cnt + 8'd1;
      case (r_state)
        ID_HI: begin
          w_id_nib_nx = data_i[3:0];
          w_state_nx  = ID_LO;
        end
        ID_LO: begin
          w_state_nx = CRC_HI;
          w_fwd_nx   = 1'b0;
          if (r_id_nib == VOSPI_DISCARD_NIBBLE) begin
            w_discard_nx = 1'b1;
          end else if (w_num == 12'd0) begin
            w_fwd_nx      = 1'b1;
            w_line_nx     = '0;
            w_expected_nx = 12'd1;
            w_sync_err_nx = (r_expected != 12'd0);
          end else if (w_num == r_expected && w_num < LINES_NUM) begin
            w_fwd_nx      = 1'b1;
            w_line_nx     = w_num[LINE_W-1:0];
            w_expected_nx = w_num + 12'd1;
          end else begin
            w_sync_err_nx = 1'b1;
            w_expected_nx = 12'd0;
          end
        end
        CRC_HI: w_state_nx = CRC_LO;
        CRC_LO: w_state_nx = PAYLOAD;
        PAYLOAD: begin
          if (r_fwd) begin
            w_coll_valid_nx  = 1'b1;
            w_coll_data_nx   = data_i;
            w_frame_start_nx = (r_line == '0) && (r_byte_cnt == HDR_CNT);
          end
          if (r_byte_cnt == LAST_BYTE) begin
            w_state_nx    = ID_HI;
            w_byte_cnt_nx = 8'd0;
            if (r_fwd) begin
              if (!w_crc_ok) begin
                w_sync_err_nx = 1'b1;
                w_expected_nx = 12'd0;
              end else if (r_line == LAST_LINE) begin
                w_frame_done_nx = 1'b1;
                w_expected_nx   = 12'd0;
              end
            end
          end
        end
        default: begin
          w_state_nx    = ID_HI;
          w_byte_cnt_nx = 8'd0;
        end
      endcase
    end else if (r_byte_cnt != 8'd0 && r_idle_cnt == IDLE_TRIP) begin
      // Stalled mid-packet: abandon it and hunt for line 0 again.
      w_state_nx    = ID_HI;
      w_byte_cnt_nx = 8'd0;
      w_expected_nx = 12'd0;
      w_fwd_nx      = 1'b0;
      w_sync_err_nx = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= ID_HI;
      r_byte_cnt    <= 8'd0;
      r_idle_cnt    <= '0;
      r_expected    <= 12'd0;
      r_id_nib      <= 4'd0;
      r_fwd         <= 1'b0;
      r_line        <= '0;
      r_coll_data   <= 8'd0;
      r_coll_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_sync_err    <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_byte_cnt    <= w_byte_cnt_nx;
      r_idle_cnt    <= w_idle_cnt_nx;
      r_expected    <= w_expected_nx;
      r_id_nib      <= w_id_nib_nx;
      r_fwd         <= w_fwd_nx;
      r_line        <= w_line_nx;
      r_coll_data   <= w_coll_data_nx;
      r_coll_valid  <= w_coll_valid_nx;
      r_frame_start <= w_frame_start_nx;
      r_frame_done  <= w_frame_done_nx;
      r_sync_err    <= w_sync_err_nx;
      r_discard     <= w_discard_nx;
    end
  end

  assign coll_data_o   = r_coll_data;
  assign coll_valid_o  = r_coll_valid;
  assign line_o        = r_line;
  assign frame_start_o = r_frame_start;
  assign frame_done_o  = r_frame_done;
  assign sync_err_o    = r_sync_err;
  assign discard_o     = r_discard;

endmodule
